// File: rtl/apb_spi_fifo_slave.sv
// APB register front-end for an SPI core: control/baud/status registers plus
// TX and RX word FIFOs that the core drains and fills.
module apb_spi_fifo_slave #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic [2:0]        paddr,
   input  logic              pwrite,
   input  logic              psel,
   input  logic              penable,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              mstr,
   output logic              cpol,
   output logic              cpha,
   output logic              lsbfe,
   output logic              spe,
   output logic              spiswai,
   output logic [2:0]        sppr,
   output logic [2:0]        spr,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_pop,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_push,
   output logic              spi_interrupt_request
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state_q, state_d;

   logic [7:0]        cr1_q, br_q;
   logic              cr2_q, ovr_q, irq_q;
   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [AW-1:0]     tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
   logic [CW-1:0]     tx_cnt_q, rx_cnt_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (psel && !penable) state_d = SETUP;
         SETUP:   if (!psel) state_d = IDLE;
                  else if (penable) state_d = ACCESS;
         ACCESS:  state_d = (psel && !penable) ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n)
      if (!preset_n) state_q <= IDLE;
      else           state_q <= state_d;

   logic acc, is_dr, is_sr, bad_addr, tx_full, rx_full, rx_empty, tx_empty, err;
   logic wr_ok, rd_ok, tx_push_en, tx_pop_en, rx_rd, rx_wr, ovr_set, ovr_clr;
   logic [7:0] sr;

   assign acc      = (state_q == ACCESS);
   assign is_dr    = (paddr == 3'd5);
   assign is_sr    = (paddr == 3'd3);
   assign bad_addr = (paddr == 3'd4) || (paddr == 3'd6) || (paddr == 3'd7);
   assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
   assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_empty = (rx_cnt_q == '0);

   // Full/empty are judged on pre-cycle occupancy, so a same-cycle core pop
   // never rescues a write to a full TX FIFO.
   assign err   = acc && (bad_addr || (pwrite && is_dr && tx_full) ||
                          (!pwrite && is_dr && rx_empty));
   assign wr_ok = acc && pwrite && !err;
   assign rd_ok = acc && !pwrite && !err;

   assign tx_push_en = wr_ok && is_dr && spe;
   assign tx_pop_en  = tx_pop && !tx_empty && spe;
   assign rx_rd      = rd_ok && is_dr;
   assign rx_wr      = rx_push && spe && (!rx_full || rx_rd);
   assign ovr_set    = rx_push && spe && rx_full && !rx_rd;
   assign ovr_clr    = wr_ok && is_sr && pwdata[4];

   assign sr = {!rx_empty, 1'b0, !tx_full, ovr_q, tx_empty, rx_full, 2'b00};

   always_comb begin
      prdata = '0;
      if (rd_ok)
         case (paddr)
            3'd0:    prdata = DATA_W'(cr1_q);
            3'd1:    prdata = DATA_W'({6'b0, cr2_q, 1'b0});
            3'd2:    prdata = DATA_W'(br_q);
            3'd3:    prdata = DATA_W'(sr);
            3'd5:    prdata = rx_mem[rx_rd_q];
            default: prdata = '0;
         endcase
   end

   always_ff @(posedge pclk or negedge preset_n)
      if (!preset_n) begin
         cr1_q <= 8'h04;
         cr2_q <= 1'b0;
         br_q  <= 8'h00;
         ovr_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (wr_ok && paddr == 3'd0) cr1_q <= pwdata[7:0] & 8'hFD;
         if (wr_ok && paddr == 3'd1) cr2_q <= pwdata[1];
         if (wr_ok && paddr == 3'd2) br_q  <= pwdata[7:0] & 8'h77;
         if (ovr_set)      ovr_q <= 1'b1;
         else if (ovr_clr) ovr_q <= 1'b0;
         irq_q <= (cr1_q[7] && (!rx_empty || ovr_q)) || (cr1_q[5] && !tx_full && spe);
      end

   // Disabling the port flushes both FIFOs every cycle it stays disabled.
   always_ff @(posedge pclk or negedge preset_n)
      if (!preset_n || !spe) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_push_en) tx_wr_q <= tx_wr_q + AW'(1);
         if (tx_pop_en)  tx_rd_q <= tx_rd_q + AW'(1);
         if (rx_wr)      rx_wr_q <= rx_wr_q + AW'(1);
         if (rx_rd)      rx_rd_q <= rx_rd_q + AW'(1);
         tx_cnt_q <= tx_cnt_q + CW'(tx_push_en) - CW'(tx_pop_en);
         rx_cnt_q <= rx_cnt_q + CW'(rx_wr) - CW'(rx_rd);
      end

   always_ff @(posedge pclk) begin
      if (tx_push_en) tx_mem[tx_wr_q] <= pwdata;
      if (rx_wr)      rx_mem[rx_wr_q] <= rx_data;
   end

   assign pready   = acc;
   assign pslverr  = err;
   assign spe      = cr1_q[6];
   assign mstr     = cr1_q[4];
   assign cpol     = cr1_q[3];
   assign cpha     = cr1_q[2];
   assign lsbfe    = cr1_q[0];
   assign spiswai  = cr2_q;
   assign sppr     = br_q[6:4];
   assign spr      = br_q[2:0];
   assign tx_data  = tx_mem[tx_rd_q];
   assign tx_valid = spe && !tx_empty;
   assign spi_interrupt_request = irq_q;
endmodule

// File: tb/tb_apb_spi_fifo_slave.sv
// Randomized scoreboard bench for apb_spi_fifo_slave against a queue-based
// model of the register file and both FIFOs.
module tb_apb_spi_fifo_slave;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          pclk = 1'b0, preset_n = 1'b0;
   logic [2:0]    paddr = '0;
   logic          pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
   logic [DW-1:0] pwdata = '0, prdata;
   logic          pready, pslverr;
   logic          mstr, cpol, cpha, lsbfe, spe, spiswai;
   logic [2:0]    sppr, spr;
   logic [DW-1:0] tx_data, rx_data = '0;
   logic          tx_valid, tx_pop = 1'b0, rx_push = 1'b0, irq;

   apb_spi_fifo_slave #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pwrite(pwrite),
      .psel(psel), .penable(penable), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .mstr(mstr), .cpol(cpol),
      .cpha(cpha), .lsbfe(lsbfe), .spe(spe), .spiswai(spiswai),
      .sppr(sppr), .spr(spr), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_pop(tx_pop), .rx_data(rx_data), .rx_push(rx_push),
      .spi_interrupt_request(irq));

   always #5 pclk = ~pclk;

   int n_cmp = 0, n_err = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      string         tag;
   } exp_t;
   exp_t sb[$];

   // Reference model
   logic [7:0]    m_cr1 = 8'h04, m_cr2 = 8'h00, m_br = 8'h00;
   bit            m_ovr = 1'b0;
   logic [DW-1:0] m_tx[$], m_rx[$];

   function automatic logic [7:0] m_sr();
      return {m_rx.size() != 0, 1'b0, m_tx.size() < DEPTH, m_ovr,
              m_tx.size() == 0, m_rx.size() == DEPTH, 2'b00};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge pclk) begin : mon
      exp_t e;
      if (preset_n && pready) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pready: got err=%0b data=%0h expected no transfer", pslverr, prdata);
         end else begin
            e = sb.pop_front();
            if ({pslverr, prdata} !== {e.err, e.data}) begin
               n_err++;
               $display("FAIL %s: got err=%0b data=%0h expected err=%0b data=%0h",
                        e.tag, pslverr, prdata, e.err, e.data);
            end
         end
      end
   end

   task automatic apb(input bit wr, input logic [2:0] a, input logic [DW-1:0] d,
                      input bit ps = 1'b0, input logic [DW-1:0] pd = '0);
      exp_t e;
      int   n;
      bit   bad;
      bad   = (a == 3'd4) || (a == 3'd6) || (a == 3'd7);
      e.data = '0;
      e.tag  = $sformatf("%s_a%0d_t%0t", wr ? "wr" : "rd", a, $time);
      if (wr) begin
         e.err = bad || (a == 3'd5 && m_tx.size() == DEPTH);
         if (!e.err)
            case (a)
               3'd0: begin
                  m_cr1 = d[7:0] & 8'hFD;
                  if (!m_cr1[6]) begin m_tx.delete(); m_rx.delete(); end
               end
               3'd1: m_cr2 = d[7:0] & 8'h02;
               3'd2: m_br  = d[7:0] & 8'h77;
               3'd3: if (d[4]) m_ovr = 1'b0;
               3'd5: if (m_cr1[6]) m_tx.push_back(d);
               default: ;
            endcase
      end else begin
         e.err = bad || (a == 3'd5 && m_rx.size() == 0);
         if (!e.err)
            case (a)
               3'd0: e.data = m_cr1;
               3'd1: e.data = m_cr2;
               3'd2: e.data = m_br;
               3'd3: e.data = m_sr();
               3'd5: e.data = m_rx.pop_front();
               default: ;
            endcase
      end
      if (ps && m_cr1[6]) begin
         if (m_rx.size() < DEPTH) m_rx.push_back(pd);
         else m_ovr = 1'b1;
      end
      sb.push_back(e);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0;
      while (!pready && n < 8) begin @(posedge pclk); #1; n++; end
      if (!pready) begin
         n_cmp++; n_err++;
         $display("FAIL pready_timeout: got 0 expected 1 at addr %0d", a);
         void'(sb.pop_back());
      end
      if (ps) begin rx_push = 1'b1; rx_data = pd; end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; rx_push = 1'b0;
   endtask

   task automatic do_rx_push(input logic [DW-1:0] v);
      if (m_cr1[6]) begin
         if (m_rx.size() < DEPTH) m_rx.push_back(v);
         else m_ovr = 1'b1;
      end
      @(posedge pclk); #1;
      rx_push = 1'b1; rx_data = v;
      @(posedge pclk); #1;
      rx_push = 1'b0;
   endtask

   task automatic do_tx_pop();
      if (m_cr1[6] && m_tx.size() > 0) void'(m_tx.pop_front());
      @(posedge pclk); #1;
      tx_pop = 1'b1;
      @(posedge pclk); #1;
      tx_pop = 1'b0;
   endtask

   task automatic check_out(input string tag);
      bit tv;
      bit ei;
      @(posedge pclk); #1;
      tv = m_cr1[6] && m_tx.size() > 0;
      ei = (m_cr1[7] && (m_rx.size() > 0 || m_ovr)) ||
           (m_cr1[5] && m_tx.size() < DEPTH && m_cr1[6]);
      chk({tag, ":tx_valid"}, 32'(tx_valid), 32'(tv));
      if (tv) chk({tag, ":tx_data"}, 32'(tx_data), 32'(m_tx[0]));
      chk({tag, ":irq"}, 32'(irq), 32'(ei));
      chk({tag, ":cfg"}, 32'({mstr, cpol, cpha, lsbfe, spe, spiswai, sppr, spr}),
          32'({m_cr1[4], m_cr1[3], m_cr1[2], m_cr1[0], m_cr1[6], m_cr2[1],
               m_br[6:4], m_br[2:0]}));
   endtask

   initial begin
      int n;
      repeat (3) @(posedge pclk);
      #1;
      chk("rst:pready", 32'(pready), 0);
      chk("rst:pslverr", 32'(pslverr), 0);
      chk("rst:prdata", 32'(prdata), 0);
      chk("rst:tx_valid", 32'(tx_valid), 0);
      chk("rst:irq", 32'(irq), 0);
      chk("rst:cpha", 32'(cpha), 1);
      preset_n = 1'b1;

      // Register write/read-back
      apb(1, 0, 8'h51); apb(1, 1, 8'h02); apb(1, 2, 8'h23);
      apb(0, 0, 0); apb(0, 1, 0); apb(0, 2, 0);
      check_out("cfg");

      // TX fill to overflow, then drain from the core side
      for (int i = 0; i < 5; i++) apb(1, 5, 8'hA1 + 8'(i));
      check_out("tx_full");
      apb(0, 3, 0);
      for (int i = 0; i < 4; i++) begin do_tx_pop(); check_out("tx_pop"); end
      do_tx_pop(); check_out("tx_pop_empty");

      // RX overflow with TX full
      for (int i = 0; i < 4; i++) apb(1, 5, 8'hB0 + 8'(i));
      for (int i = 0; i < 5; i++) do_rx_push(8'h11 + 8'(i));
      apb(0, 3, 0);
      for (int i = 0; i < 5; i++) apb(0, 5, 0);

      // Same-cycle DR read and push into a full RX FIFO
      apb(1, 3, 8'h10);
      for (int i = 0; i < 4; i++) do_rx_push(8'h21 + 8'(i));
      apb(0, 5, 0, 1'b1, 8'h77);
      apb(0, 3, 0);
      for (int i = 0; i < 4; i++) apb(0, 5, 0);

      // Bad address, overflow interrupt and its clear
      apb(1, 0, 8'hD1);
      for (int i = 0; i < 5; i++) do_rx_push(8'h31 + 8'(i));
      check_out("irq_ovr");
      apb(0, 6, 0); apb(1, 6, 8'hFF); apb(0, 4, 0); apb(1, 7, 8'h01);
      apb(1, 3, 8'h10); apb(0, 3, 0);
      for (int i = 0; i < 4; i++) apb(0, 5, 0);
      check_out("irq_clr");

      // Disable flushes, ignores pushes, keeps ovr
      for (int i = 0; i < 5; i++) do_rx_push(8'h41 + 8'(i));
      apb(1, 5, 8'h55);
      apb(1, 0, 8'h11);
      check_out("spe0");
      do_rx_push(8'h99);
      apb(0, 3, 0); apb(0, 5, 0);
      apb(1, 0, 8'h51);

      // Randomized traffic
      for (int k = 0; k < 300; k++) begin
         logic [7:0] d;
         int op;
         op = $urandom_range(0, 9);
         d  = 8'($urandom);
         case (op)
            0, 1, 2, 3: begin
               logic [2:0] a;
               a = 3'($urandom_range(0, 7));
               if (a == 3'd0 && $urandom_range(0, 7) != 0) d[6] = 1'b1;
               apb(1'($urandom_range(0, 1)), a, d);
            end
            4, 5:    do_rx_push(d);
            6, 7:    do_tx_pop();
            8:       apb(1, 5, d);
            default: apb(0, 5, 0, 1'($urandom_range(0, 1)), d);
         endcase
         check_out("rand");
      end

      // Reset in the middle of an ACCESS with FIFOs half full
      apb(1, 0, 8'h51);
      apb(1, 5, 8'hC1); apb(1, 5, 8'hC2);
      do_rx_push(8'hD1); do_rx_push(8'hD2);
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 3'd0;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      chk("pre_rst:pready", 32'(pready), 1);
      preset_n = 1'b0;
      #1;
      chk("mid_rst:pready", 32'(pready), 0);
      chk("mid_rst:tx_valid", 32'(tx_valid), 0);
      chk("mid_rst:prdata", 32'(prdata), 0);
      psel = 1'b0; penable = 1'b0;
      m_cr1 = 8'h04; m_cr2 = 8'h00; m_br = 8'h00; m_ovr = 1'b0;
      m_tx.delete(); m_rx.delete();
      @(posedge pclk); #1;
      preset_n = 1'b1;
      apb(0, 0, 0); apb(0, 3, 0);
      apb(1, 0, 8'h40); apb(0, 3, 0);
      check_out("post_rst");

      n = 0;
      while (sb.size() != 0 && n < 20) begin @(posedge pclk); n++; end
      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
